// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encodings and saturating update.
package bp_pkg;

    typedef logic [1:0] cnt_t;

    localparam cnt_t SNT      = 2'b00;
    localparam cnt_t WNT      = 2'b01;
    localparam cnt_t WT       = 2'b10;
    localparam cnt_t ST       = 2'b11;
    localparam cnt_t CNT_INIT = WNT;

    function automatic cnt_t sat_update(input cnt_t cnt, input logic taken);
        cnt_t nxt;
        nxt = cnt;
        if (taken) begin
            if (cnt != ST) nxt = cnt + 2'b01;
        end else begin
            if (cnt != SNT) nxt = cnt - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/gshare_pht_if.sv
// Predict/resolve bus between the fetch side (master) and the pattern history table (slave).
interface gshare_pht_if #(
    parameter int w_pht = 4
);
    logic             EN;
    logic             predict;
    logic [w_pht-1:0] pc_idx;
    logic [w_pht-1:0] gbhr;
    logic             resolve;
    logic             br_taken;
    logic             pred_valid;
    logic             pred_taken;
    logic             mispredict;
    logic             resolve_valid;
    logic             fifo_full;
    logic             fifo_empty;

    modport master (
        output EN, predict, pc_idx, gbhr, resolve, br_taken,
        input  pred_valid, pred_taken, mispredict, resolve_valid, fifo_full, fifo_empty
    );

    modport slave (
        input  EN, predict, pc_idx, gbhr, resolve, br_taken,
        output pred_valid, pred_taken, mispredict, resolve_valid, fifo_full, fifo_empty
    );
endinterface

// File: rtl/bp_inflight_fifo.sv
// Synchronous FIFO holding {index, prediction} of branches awaiting resolve.
// Latency: pushed data readable at dout the cycle after push; full/empty registered.
// Backpressure: caller must not push when full (unless popping) nor pop when empty.
module bp_inflight_fifo #(
    parameter int width = 5,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int aw = $clog2(depth);
    localparam logic [aw:0] depth_c = (aw+1)'(depth);

    logic [width-1:0] mem [depth];
    logic [aw-1:0]    wr_ptr;
    logic [aw-1:0]    rd_ptr;
    logic [aw:0]      count;
    logic [aw:0]      count_nxt;

    assign dout = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push && !pop) count_nxt = count + 1'b1;
        if (pop && !push) count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == depth_c);
            empty <= (count_nxt == '0);
        end
    end
endmodule

// File: rtl/gshare_pht.sv
// Gshare pattern history table: XOR-indexed 2-bit counters trained at resolve.
// Latency: prediction and mispredict/resolve pulses one cycle after acceptance.
// Backpressure: predicts dropped when in-flight FIFO full without a same-cycle resolve.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int w_pht = 4,
    parameter int depth = 4
) (
    input  logic           clk,
    input  logic           rst,
    gshare_pht_if.slave    bp
);
    localparam int n_cnt = 2 ** w_pht;

    cnt_t             cnt [n_cnt];
    logic [w_pht-1:0] idx;
    logic [w_pht-1:0] ridx;
    logic             rpred;
    logic [w_pht:0]   fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             res_acc;
    logic             pred_acc;

    assign idx      = bp.pc_idx ^ bp.gbhr;
    assign ridx     = fifo_dout[w_pht:1];
    assign rpred    = fifo_dout[0];
    assign res_acc  = bp.EN && bp.resolve && !fifo_empty;
    assign pred_acc = bp.EN && bp.predict && (!fifo_full || res_acc);

    assign bp.fifo_full  = fifo_full;
    assign bp.fifo_empty = fifo_empty;

    bp_inflight_fifo #(
        .width (w_pht + 1),
        .depth (depth)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (pred_acc),
        .din   ({idx, cnt[idx][1]}),
        .pop   (res_acc),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Prediction reads the pre-update counter when it collides with the trained entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < n_cnt; i++) cnt[i] <= CNT_INIT;
        end else if (res_acc) begin
            cnt[ridx] <= sat_update(cnt[ridx], bp.br_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bp.pred_valid    <= 1'b0;
            bp.pred_taken    <= 1'b0;
            bp.mispredict    <= 1'b0;
            bp.resolve_valid <= 1'b0;
        end else begin
            bp.pred_valid    <= pred_acc;
            bp.resolve_valid <= res_acc;
            bp.mispredict    <= res_acc && (rpred != bp.br_taken);
            if (pred_acc) bp.pred_taken <= cnt[idx][1];
        end
    end
endmodule

// File: tb/tb_gshare_pht.sv
// Randomized and directed check of gshare_pht against a queue/array reference model.
module tb_gshare_pht;
    localparam int W = 4;
    localparam int D = 4;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    gshare_pht_if #(.w_pht(W)) bus ();
    gshare_pht #(.w_pht(W), .depth(D)) dut (.clk(clk), .rst(rst), .bp(bus));

    int n_cmp = 0;
    int n_mis = 0;

    int m_cnt [N];
    int mq_idx [$];
    int mq_pred [$];
    bit e_pv, e_pt, e_mp, e_rv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, input bit en, input bit pr, input int pc, input int gh,
                         input bit rs, input bit bt);
        int i, ri, rp;
        bit racc, pacc, ptn;
        if (r) begin
            for (int k = 0; k < N; k++) m_cnt[k] = 1;
            mq_idx.delete();
            mq_pred.delete();
            e_pv = 0; e_pt = 0; e_mp = 0; e_rv = 0;
            return;
        end
        racc = en && rs && (mq_idx.size() > 0);
        pacc = en && pr && ((mq_idx.size() < D) || racc);
        i    = (pc ^ gh) % N;
        ptn  = (m_cnt[i] >= 2);
        e_pv = pacc;
        e_rv = racc;
        e_mp = 0;
        if (racc) begin
            ri = mq_idx.pop_front();
            rp = mq_pred.pop_front();
            e_mp = (rp != int'(bt));
            if (bt) m_cnt[ri] = (m_cnt[ri] == 3) ? 3 : m_cnt[ri] + 1;
            else    m_cnt[ri] = (m_cnt[ri] == 0) ? 0 : m_cnt[ri] - 1;
        end
        if (pacc) begin
            e_pt = ptn;
            mq_idx.push_back(i);
            mq_pred.push_back(int'(ptn));
        end
    endtask

    task automatic step(input bit r, input bit en, input bit pr, input int pc, input int gh,
                        input bit rs, input bit bt);
        rst          = r;
        bus.EN       = en;
        bus.predict  = pr;
        bus.pc_idx   = W'(pc);
        bus.gbhr     = W'(gh);
        bus.resolve  = rs;
        bus.br_taken = bt;
        @(posedge clk);
        model(r, en, pr, pc, gh, rs, bt);
        @(negedge clk);
        chk("pred_valid",    bus.pred_valid,    e_pv);
        chk("pred_taken",    bus.pred_taken,    e_pt);
        chk("mispredict",    bus.mispredict,    e_mp);
        chk("resolve_valid", bus.resolve_valid, e_rv);
        chk("fifo_full",     bus.fifo_full,     mq_idx.size() == D);
        chk("fifo_empty",    bus.fifo_empty,    mq_idx.size() == 0);
    endtask

    task automatic do_rst();                           step(1, 0, 0, 0, 0, 0, 0); endtask
    task automatic do_pred(input int pc, input int gh); step(0, 1, 1, pc, gh, 0, 0); endtask
    task automatic do_res(input bit bt);               step(0, 1, 0, 0, 0, 1, bt); endtask
    task automatic do_both(input int pc, input int gh, input bit bt); step(0, 1, 1, pc, gh, 1, bt); endtask

    initial begin
        rst = 1; bus.EN = 0; bus.predict = 0; bus.pc_idx = '0; bus.gbhr = '0;
        bus.resolve = 0; bus.br_taken = 0;
        @(negedge clk);
        do_rst();
        do_rst();
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_full",  bus.fifo_full,  0);
        chk("rst_pv",    bus.pred_valid, 0);

        // First branch on idx 6, trained taken up to saturation.
        do_pred(3, 5);
        chk("first_pv", bus.pred_valid, 1);
        chk("first_pt", bus.pred_taken, 0);
        chk("first_empty", bus.fifo_empty, 0);
        do_res(1);
        chk("first_rv", bus.resolve_valid, 1);
        chk("first_mp", bus.mispredict, 1);
        for (int k = 0; k < 3; k++) begin
            do_pred(6, 0);
            chk("sat_pt", bus.pred_taken, 1);
            do_res(1);
            chk("sat_mp", bus.mispredict, 0);
        end

        // Fill, drop on full, then predict+resolve while full.
        for (int k = 0; k < 4; k++) do_pred(0, 0);
        chk("full_set", bus.fifo_full, 1);
        do_pred(1, 0);
        chk("drop_pv", bus.pred_valid, 0);
        chk("drop_full", bus.fifo_full, 1);
        do_both(1, 0, 0);
        chk("full_both_pv", bus.pred_valid, 1);
        chk("full_both_full", bus.fifo_full, 1);
        for (int k = 0; k < 4; k++) do_res(0);

        // Read-before-write on the same index.
        do_rst();
        do_pred(6, 0);
        do_both(6, 0, 1);
        chk("rbw_pt", bus.pred_taken, 0);
        chk("rbw_mp", bus.mispredict, 1);
        do_pred(6, 0);
        chk("rbw_next_pt", bus.pred_taken, 1);
        do_res(0);
        do_res(0);

        // Resolve on empty, then enable low.
        do_rst();
        do_res(1);
        chk("empty_rv", bus.resolve_valid, 0);
        chk("empty_mp", bus.mispredict, 0);
        do_pred(2, 0);
        step(0, 0, 1, 2, 0, 1, 1);
        chk("en0_pv", bus.pred_valid, 0);
        chk("en0_rv", bus.resolve_valid, 0);
        chk("en0_empty", bus.fifo_empty, 0);
        do_res(0);

        // Reset with entries in flight and counter[2] saturated.
        do_rst();
        do_pred(2, 0);
        do_both(2, 0, 1);
        do_res(1);
        for (int k = 0; k < 3; k++) do_pred(0, 2);
        chk("pre_rst_pt", bus.pred_taken, 1);
        do_rst();
        chk("mid_rst_empty", bus.fifo_empty, 1);
        chk("mid_rst_pv", bus.pred_valid, 0);
        do_pred(2, 0);
        chk("post_rst_pt", bus.pred_taken, 0);

        // Random traffic with a small index spread for collisions.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(0, 79) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/gshare_pht.md
Name: gshare_pht

Overview:
- Pattern history table for the gshare branch predictor, the stage directly downstream of the global branch history register.
- Indexes 2^w_pht two-bit saturating counters with (pc_idx XOR gbhr) and returns a registered taken/not-taken prediction.
- Keeps an in-flight FIFO of the index and prediction used for each branch. The counter that produced a prediction is therefore the one trained at resolve, even though the history register has shifted since.
- Produces the registered mispredict pulse consumed by fetch redirect.

Parameters:
w_pht, 4, history/index width; table holds 2^w_pht counters
depth, 4, in-flight FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
EN  input  1  global enable; when low, no state changes
predict  input  1  request a prediction this cycle
pc_idx  input  w_pht  low PC bits of the branch being predicted
gbhr  input  w_pht  current global history (from the history register)
resolve  input  1  oldest in-flight branch resolves this cycle
br_taken  input  1  actual outcome of the resolving branch
pred_valid  output  1  one-cycle pulse: pred_taken is valid
pred_taken  output  1  predicted direction (counter MSB)
mispredict  output  1  one-cycle pulse: resolved outcome != stored prediction
resolve_valid  output  1  one-cycle pulse: a resolve was accepted last cycle
fifo_full  output  1  in-flight FIFO holds depth entries
fifo_empty  output  1  in-flight FIFO holds no entries

Behaviour:
- Reset (rst=1 at posedge), regardless of EN or in-flight traffic:
  - all counters = 2'b01 (weakly not-taken).
  - FIFO pointers and count = 0.
  - pred_valid, pred_taken, mispredict, resolve_valid = 0; fifo_empty=1, fifo_full=0.
- Index is idx = pc_idx ^ gbhr, w_pht bits, no hashing beyond XOR.
- Predict, accepted when EN=1, predict=1, and (!fifo_full or a resolve is accepted the same cycle):
  - next cycle pred_valid=1 and pred_taken=counter[idx][1] (1-cycle latency).
  - push {idx, counter[idx][1]} to the FIFO.
- Predict when full with no simultaneous accepted resolve: dropped. pred_valid stays 0, no push, no error flag.
- Resolve, accepted when EN=1, resolve=1, and !fifo_empty:
  - pop the oldest {ridx, rpred}.
  - counter[ridx] updates at the same edge: saturating +1 if br_taken, else saturating -1. 11 stays 11 on taken; 00 stays 00 on not-taken.
  - next cycle resolve_valid=1 and mispredict=(rpred != br_taken).
- Resolve when FIFO empty: ignored. No counter write; resolve_valid=0, mispredict=0.
- Simultaneous accepted predict and resolve:
  - push and pop in the same cycle; count is unchanged.
  - Allowed when full, and when empty only if the predict is accepted (the resolve is still ignored because the pop needs a prior entry).
  - If idx == ridx, the prediction uses the pre-update counter (read-before-write, no bypass).
  - The update is visible to predicts issued from the next cycle onward.
- EN=0: counters, FIFO, and pointers hold; pred_valid, mispredict, and resolve_valid are driven 0 the following cycle. pred_taken holds its last value.
- Pulses are single-cycle; pred_valid is 0 in any cycle not following an accepted predict.
- Pointers wrap modulo depth. Count is a (log2(depth)+1)-bit counter; fifo_full = (count==depth), fifo_empty = (count==0). Both are registered state, not combinational from the inputs.
- Predictions are never lost once pred_valid is asserted; there is no backpressure on the outputs.

Decomposition:
- Shared package bp_pkg:
  - counter encodings SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - reset counter value CNT_INIT=WNT.
  - function sat_update(cnt, taken) returning the saturated next counter.
  - GBHR and PHT use the same w_pht.
- One sub-module, bp_inflight_fifo: parameterised synchronous FIFO (width w_pht+1, depth), with push/pop/full/empty and synchronous active-high rst. gshare_pht instantiates it and holds the counter array plus output registers.

Test Plan:
- Reset, then predict with pc_idx=4'h3, gbhr=4'h5 (idx=6) -> next cycle pred_valid=1, pred_taken=0; fifo_empty=0.
- Resolve br_taken=1 for that branch -> counter[6]=10, resolve_valid=1, mispredict=1. Then predict idx 6 -> pred_taken=1. Resolve taken 3 more times (one predict each) -> counter[6] saturates at 11, and the last three mispredicts are 0.
- Four predicts with no resolve (depth=4) -> fifo_full=1. Fifth predict -> pred_valid=0 and count stays 4. Same cycle predict+resolve while full -> pred_valid=1, count stays 4.
- Predict and resolve in the same cycle on idx 6, counter=01, br_taken=1 -> pred_taken=0 (pre-update) and counter becomes 10. A predict one cycle later on idx 6 -> pred_taken=1.
- Resolve on an empty FIFO -> resolve_valid=0, mispredict=0, all counters unchanged. EN=0 with predict=1 and resolve=1 -> no pulses and no state change.
- rst asserted with 3 entries in flight and counter[2]=11 -> the next cycle has fifo_empty=1, counter[2]=01, all pulses 0. A following predict on idx 2 -> pred_taken=0.
